// File: rtl/jk_counter_if.sv
// jk_counter_if: control and status bundle between a controller and the JK counter
interface jk_counter_if #(
   parameter int WIDTH = 4
);
   logic             en;
   logic [1:0]       mode;
   logic [WIDTH-1:0] j;
   logic [WIDTH-1:0] k;
   logic [WIDTH-1:0] d;
   logic [WIDTH-1:0] q;
   logic             tc;
   logic             wrap;
   modport master (output en, mode, j, k, d, input q, tc, wrap);
   modport slave  (input en, mode, j, k, d, output q, tc, wrap);
endinterface

// File: rtl/jk_counter.sv
// jk_counter: bank of JK stages that can also count up/down modulo MAX+1 or load in parallel
module jk_counter #(
   parameter int WIDTH = 4,
   parameter int MAX   = 2**WIDTH-1
) (
   input logic         clk,
   input logic         rst,
   jk_counter_if.slave bus
);
   localparam logic [WIDTH-1:0] LIM = WIDTH'(MAX);
   logic [WIDTH-1:0] q_q, q_d, jk_nxt;
   logic             wrap_q, wrap_d, at_top, at_bot, up, dn;
   assign up     = bus.mode == 2'b01;
   assign dn     = bus.mode == 2'b10;
   assign at_top = q_q >= LIM;
   assign at_bot = q_q == '0 || q_q > LIM;
   assign jk_nxt = (bus.j & ~q_q) | (~bus.k & q_q);
   assign q_d    = !bus.en           ? q_q :
                   bus.mode == 2'b00 ? jk_nxt :
                   up                ? (at_top ? '0 : q_q + WIDTH'(1)) :
                   dn                ? (at_bot ? LIM : q_q - WIDTH'(1)) :
                                       (bus.d > LIM ? LIM : bus.d);
   assign wrap_d = bus.en && ((up && at_top) || (dn && at_bot));
   // state registers; reset clears the count immediately, independent of clk
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         q_q    <= '0;
         wrap_q <= 1'b0;
      end else begin
         q_q    <= q_d;
         wrap_q <= wrap_d;
      end
   end
   assign bus.q    = q_q;
   assign bus.wrap = wrap_q;
   assign bus.tc   = (up && at_top) || (dn && q_q == '0);
endmodule

// File: doc/jk_counter.md
JK_COUNTER -- requirements
Module: jk_counter

Interface
REQ-001 Parameter WIDTH, default 4: number of JK stages, which is the width of q.
REQ-002 Parameter MAX, default 2**WIDTH-1: terminal value for counter modes, legal range 1..2**WIDTH-1.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset; rst=0 clears state immediately, regardless of clk.
REQ-005 en  input  1  clock enable; en=0 holds all state.
REQ-006 mode  input  2  00 JK bank, 01 count up, 10 count down, 11 parallel load.
REQ-007 j  input  WIDTH  per-stage J inputs, used in mode 00 only.
REQ-008 k  input  WIDTH  per-stage K inputs, used in mode 00 only.
REQ-009 d  input  WIDTH  parallel load data, used in mode 11 only.
REQ-010 q  output  WIDTH  registered stage outputs.
REQ-011 tc  output  1  terminal count, combinational from q and mode.
REQ-012 wrap  output  1  registered one-cycle pulse marking a counter wrap.

Function
REQ-013 All updates of q and wrap occur on the rising clk edge when rst=1.
REQ-014 en=0: q holds and wrap=0 on the next edge; mode, j, k and d are ignored.
REQ-015 Mode 00, per bit i, applied independently:
- j=0, k=0: hold.
- j=0, k=1: q[i]=0.
- j=1, k=0: q[i]=1.
- j=1, k=1: q[i] toggles.
REQ-016 Mode 00 does not limit q to MAX; any WIDTH-bit value is reachable.
REQ-017 Mode 01 (count up):
- q<MAX: q=q+1, wrap=0.
- q==MAX: q=0, wrap=1.
- q>MAX: q=0, wrap=1.
REQ-018 Mode 10 (count down):
- 0<q<=MAX: q=q-1, wrap=0.
- q==0: q=MAX, wrap=1.
- q>MAX: q=MAX, wrap=1.
REQ-019 Mode 11 (parallel load):
- d<=MAX: q=d.
- d>MAX: q=MAX (saturating).
- wrap=0.
REQ-020 wrap is 0 after every enabled edge in modes 00 and 11, and 0 whenever the preceding enabled edge did not wrap.
REQ-021 tc=1 only in these cases; otherwise tc=0:
- mode 01 and q>=MAX.
- mode 10 and q==0.
REQ-022 tc=0 in modes 00 and 11.
REQ-023 tc is unaffected by en, so it predicts a wrap on the next enabled edge.
REQ-024 A mode change takes effect on the edge where it is sampled, with no intermediate cycle; the current q is the starting point.
REQ-025 Counter-mode arithmetic is WIDTH bits, unsigned, with no overflow beyond the rules in REQ-017 and REQ-018.
REQ-026 Latency from input change to q update is one clock edge; tc has zero latency from q.

Reset
REQ-027 rst=0 forces q=0 and wrap=0 asynchronously, without waiting for clk.
REQ-028 Reset asserted mid-count abandons the count; the first enabled edge after release counts from q=0.
REQ-029 Release of rst is synchronous in effect: the first state change occurs on the first rising edge with rst=1.
REQ-030 Under reset, tc follows REQ-021 from q=0; for example, tc=1 when mode=10.

Verification
REQ-031 The bench shall run with WIDTH=4 and MAX=9 and cover at least the following directed scenarios:
- JK bank: reset, then mode 00, en=1. Apply j=1111 k=0000 -> q=1111. Then j=1010 k=0101 -> q=1010. Then j=1111 k=1111 -> q=0101. Then j=0000 k=0000 for 2 edges -> q=0101.
- Up wrap: load d=7, then mode 01 for 3 edges -> q=8, 9, 0. tc=1 while q=9. wrap=1 exactly one cycle, after q becomes 0.
- Down wrap and out-of-range: load d=0, mode 10 -> q=9 with wrap=1. Then mode 00 with j=1111 k=0000 -> q=15. Then mode 10 -> q=9, wrap=1.
- Load saturation and enable: mode 11 d=13 -> q=9. en=0 with mode 01 for 3 edges -> q stays 9, wrap=0, tc=1.
- Async reset mid-count: counting up at q=5, pull rst low between edges -> q=0 before the next edge. Release, then 2 edges -> q=1, 2.
- Simultaneous events: rst released in the same cycle as mode 11 d=6 -> q=6 on the first edge after release. Switching 01 to 10 at q=9 -> q=8, with no wrap.
